// File: rtl/lowrisc_hwrng_pool.sv
// Entropy pool: synchronised ring-oscillator bits are XOR-folded, health-tested and packed into words
// for a show-ahead FIFO. Define HWRNG_VN_DEBIAS_EN to add von Neumann debiasing ahead of the packer.
module lowrisc_hwrng_pool #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int RCT_LIMIT = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [NCH-1:0]           raw_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     health_fail_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(WIDTH);
    localparam logic [7:0] RCT_L = 8'(RCT_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HALT    = 2'd2
    } state_e;

    function automatic logic fold_bits(input logic [NCH-1:0] v);
        return ^v;
    endfunction

    logic [NCH-1:0]   sync1_r, sync2_r;
    state_e           state_r, state_s;
    logic [WIDTH-1:0] word_r, word_s;
    logic [BCW-1:0]   bit_cnt_r, bit_cnt_s;
    logic [7:0]       run_cnt_r, run_cnt_s, run_prev_s, run_next_s;
    logic             last_bit_r, last_bit_s;
    logic             fold_s, accept_s, acc_bit_s, push_s, health_set_s;
`ifdef HWRNG_VN_DEBIAS_EN
    logic             pair_phase_r, pair_phase_s, pair_first_r, pair_first_s;
`endif
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]    count_r, count_s;
    logic             full_r, full_s, empty_r, empty_s;
    logic             overflow_r, overflow_s, health_r, health_s;
    logic             pop_s, push_ok_s;

    assign fold_s = fold_bits(sync2_r);

    // Repetition count on the folded stream (ahead of any debiasing); clr restarts the run.
    always_comb begin
        run_prev_s = clr_i ? 8'd0 : run_cnt_r;
        if (run_prev_s == 8'd0 || fold_s != last_bit_r) begin
            run_next_s = 8'd1;
        end else if (run_prev_s >= RCT_L) begin
            run_next_s = RCT_L;
        end else begin
            run_next_s = run_prev_s + 8'd1;
        end
    end

    // Bit acceptance: direct, or the first bit of an unequal pair when debiasing.
    always_comb begin
        accept_s  = 1'b1;
        acc_bit_s = fold_s;
`ifdef HWRNG_VN_DEBIAS_EN
        accept_s  = pair_phase_r && (fold_s != pair_first_r);
        acc_bit_s = pair_first_r;
`else
        accept_s  = 1'b1;
`endif
    end

    // Assembler FSM next-state and word packing.
    always_comb begin
        state_s      = state_r;
        word_s       = word_r;
        bit_cnt_s    = bit_cnt_r;
        run_cnt_s    = run_prev_s;
        last_bit_s   = last_bit_r;
        push_s       = 1'b0;
        health_set_s = 1'b0;
`ifdef HWRNG_VN_DEBIAS_EN
        pair_phase_s = 1'b0;
        pair_first_s = pair_first_r;
`endif
        case (state_r)
            IDLE: begin
                word_s    = {WIDTH{1'b0}};
                bit_cnt_s = {BCW{1'b0}};
                state_s   = en_i ? COLLECT : IDLE;
            end
            COLLECT: begin
                if (!en_i) begin
                    state_s   = IDLE;
                    word_s    = {WIDTH{1'b0}};
                    bit_cnt_s = {BCW{1'b0}};
                end else begin
                    run_cnt_s  = run_next_s;
                    last_bit_s = fold_s;
                    if (run_next_s >= RCT_L) begin
                        health_set_s = 1'b1;
                        state_s      = HALT;
                        word_s       = {WIDTH{1'b0}};
                        bit_cnt_s    = {BCW{1'b0}};
                    end else begin
`ifdef HWRNG_VN_DEBIAS_EN
                        pair_phase_s = ~pair_phase_r;
                        pair_first_s = fold_s;
`endif
                        if (accept_s) begin
                            word_s = {word_r[WIDTH-2:0], acc_bit_s};
                            if (bit_cnt_r == BCW'(WIDTH - 1)) begin
                                push_s    = 1'b1;
                                bit_cnt_s = {BCW{1'b0}};
                            end else begin
                                bit_cnt_s = bit_cnt_r + BCW'(1);
                            end
                        end else begin
                            word_s = word_r;
                        end
                    end
                end
            end
            HALT: begin
                word_s    = {WIDTH{1'b0}};
                bit_cnt_s = {BCW{1'b0}};
                if (clr_i) begin
                    state_s = en_i ? COLLECT : IDLE;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s   = IDLE;
                word_s    = {WIDTH{1'b0}};
                bit_cnt_s = {BCW{1'b0}};
            end
        endcase
    end

    // FIFO pointer/occupancy bookkeeping and sticky flags (a set beats clr).
    always_comb begin
        pop_s     = !empty_r && rd_ready_i;
        push_ok_s = push_s && (!full_r || pop_s);
        wr_ptr_s  = push_ok_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
        rd_ptr_s  = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
        full_s     = (count_s == CW'(DEPTH));
        empty_s    = (count_s == {CW{1'b0}});
        overflow_s = (push_s && !push_ok_s) ? 1'b1 : (clr_i ? 1'b0 : overflow_r);
        health_s   = health_set_s ? 1'b1 : (clr_i ? 1'b0 : health_r);
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r    <= {NCH{1'b0}};
            sync2_r    <= {NCH{1'b0}};
            state_r    <= IDLE;
            word_r     <= {WIDTH{1'b0}};
            bit_cnt_r  <= {BCW{1'b0}};
            run_cnt_r  <= 8'd0;
            last_bit_r <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            health_r   <= 1'b0;
`ifdef HWRNG_VN_DEBIAS_EN
            pair_phase_r <= 1'b0;
            pair_first_r <= 1'b0;
`endif
        end else begin
            sync1_r    <= raw_i;
            sync2_r    <= sync1_r;
            state_r    <= state_s;
            word_r     <= word_s;
            bit_cnt_r  <= bit_cnt_s;
            run_cnt_r  <= run_cnt_s;
            last_bit_r <= last_bit_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            full_r     <= full_s;
            empty_r    <= empty_s;
            overflow_r <= overflow_s;
            health_r   <= health_s;
`ifdef HWRNG_VN_DEBIAS_EN
            pair_phase_r <= pair_phase_s;
            pair_first_r <= pair_first_s;
`endif
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    assign rd_valid_o    = !empty_r;
    assign rd_data_o     = mem_r[rd_ptr_r];
    assign count_o       = count_r;
    assign full_o        = full_r;
    assign empty_o       = empty_r;
    assign overflow_o    = overflow_r;
    assign health_fail_o = health_r;

endmodule
